// File: rtl/matrix_pkg.sv
// matrix_pkg: font geometry, 5x7 digit glyphs (column-major, bit 0 = top row) and scan states
package matrix_pkg;
  localparam int NUM_GLYPHS = 10;
  localparam int FONT_COLS = 5;
  localparam int FONT_ROWS = 7;
  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_e;
  localparam logic [FONT_ROWS-1:0] GLYPH [NUM_GLYPHS][FONT_COLS] = '{
    '{7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E},
    '{7'h00, 7'h42, 7'h7F, 7'h40, 7'h00},
    '{7'h42, 7'h61, 7'h51, 7'h49, 7'h46},
    '{7'h21, 7'h41, 7'h45, 7'h4B, 7'h31},
    '{7'h18, 7'h14, 7'h12, 7'h7F, 7'h10},
    '{7'h27, 7'h45, 7'h45, 7'h45, 7'h39},
    '{7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30},
    '{7'h01, 7'h71, 7'h09, 7'h05, 7'h03},
    '{7'h36, 7'h49, 7'h49, 7'h49, 7'h36},
    '{7'h06, 7'h49, 7'h49, 7'h29, 7'h1E}
  };
endpackage

// File: rtl/glyph_rom.sv
// glyph_rom: combinational font lookup; columns outside the font and invalid codes read as blank
module glyph_rom
  import matrix_pkg::*;
#(
  parameter int N_ROWS = 7,
  parameter int CODE_W = 5,
  parameter int COL_W = 3
) (
  input  logic [CODE_W-1:0] code,
  input  logic [COL_W-1:0]  col_idx,
  output logic [N_ROWS-1:0] row,
  output logic              valid
);
  localparam int GW = $clog2(NUM_GLYPHS);
  localparam int FW = $clog2(FONT_COLS);
  logic in_font;
  logic [GW-1:0] gi;
  logic [FW-1:0] fi;
  always_comb begin
    valid = 32'(code) < NUM_GLYPHS;
    in_font = 32'(col_idx) < FONT_COLS;
    gi = valid ? GW'(code) : '0;
    fi = in_font ? FW'(col_idx) : '0;
    row = valid && in_font ? N_ROWS'(GLYPH[gi][fi]) : '0;
  end
endmodule

// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: column-multiplexed LED matrix scanner with frame-boundary code double-buffering
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int N_COLS = 5,
  parameter int N_ROWS = 7,
  parameter int CODE_W = 5,
  parameter int DIV = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [CODE_W-1:0] code,
  input  logic              code_valid,
  output logic [N_COLS-1:0] col,
  output logic [N_ROWS-1:0] row,
  output logic              display,
  output logic              frame_done
);
  localparam int TMAX = DIV > BLANK_CYCLES ? (DIV > 2 ? DIV : 2) : (BLANK_CYCLES > 2 ? BLANK_CYCLES : 2);
  localparam int TW = $clog2(TMAX);
  localparam int CW = $clog2(N_COLS);
  localparam logic [TW-1:0] DIV_LAST = TW'(DIV - 1);
  localparam logic [TW-1:0] BLK_LAST = TW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
  state_e state_q, state_d;
  logic [CODE_W-1:0] pending_q, pending_d, active_q, active_d;
  logic [CW-1:0] col_idx_q, col_idx_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [N_COLS-1:0] col_q;
  logic [N_ROWS-1:0] row_q, glyph_row;
  logic display_q, frame_done_q, adv, wrap, glyph_ok;
  always_comb begin
    pending_d = code_valid ? code : pending_q;
    state_d = state_q;
    active_d = active_q;
    col_idx_d = col_idx_q;
    tick_d = tick_q;
    adv = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      col_idx_d = '0;
      tick_d = '0;
    end else if (state_q == IDLE) begin
      state_d = SCAN;
      active_d = pending_q;
      col_idx_d = '0;
      tick_d = '0;
    end else if (state_q == SCAN) begin
      tick_d = tick_q == DIV_LAST ? '0 : tick_q + 1'b1;
      state_d = tick_q == DIV_LAST && BLANK_CYCLES > 0 ? BLANK : SCAN;
      adv = tick_q == DIV_LAST && BLANK_CYCLES == 0;
    end else begin
      tick_d = tick_q == BLK_LAST ? '0 : tick_q + 1'b1;
      adv = tick_q == BLK_LAST;
      state_d = adv ? SCAN : BLANK;
    end
    wrap = adv && col_idx_q == COL_LAST;
    if (adv) col_idx_d = wrap ? '0 : col_idx_q + 1'b1;
    // a strobe on the wrap edge itself is taken into the new frame
    if (wrap) active_d = pending_d;
  end
  glyph_rom #(.N_ROWS(N_ROWS), .CODE_W(CODE_W), .COL_W(CW)) u_rom (
    .code(active_d), .col_idx(col_idx_d), .row(glyph_row), .valid(glyph_ok)
  );
  // outputs register from next-state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pending_q <= '0;
      active_q <= '0;
      col_idx_q <= '0;
      tick_q <= '0;
      col_q <= '0;
      row_q <= '0;
      display_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      active_q <= active_d;
      col_idx_q <= col_idx_d;
      tick_q <= tick_d;
      col_q <= state_d == SCAN ? N_COLS'(1) << col_idx_d : '0;
      row_q <= state_d == SCAN ? glyph_row : '0;
      display_q <= state_d == SCAN ? glyph_ok : (state_d == BLANK && display_q);
      frame_done_q <= wrap;
    end
  end
  assign col = col_q;
  assign row = row_q;
  assign display = display_q;
  assign frame_done = frame_done_q;
endmodule
